mac_feed_sequencer: RTL and testbench
=====================================

MAC_FEED_SEQUENCER -- requirements
Module: mac_feed_sequencer

Interface
REQ-001 Parameter MAC_NUM, default 1, number of MAC rows fed in parallel.
REQ-002 Parameter ACCU_NUM_LOG2, default 1; ACCU_NUM = 2**ACCU_NUM_LOG2, lanes per MAC row.
REQ-003 Parameter BW_ACT, default 8, activation/result width; BW_WET, default 8, weight width; DIM_W, default 16, dimension/address width.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  clock, all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle job request; sampled only in IDLE.
REQ-008 cfg_rows / cfg_inner / cfg_cols  in  DIM_W each  output rows, inner (reduction) length, output columns; latched on accepted start.
REQ-009 cfg_shift  in  8  result shift, latched on start, driven on pe_res_shift_num.
REQ-010 busy  out  1  high from accepted start until done; done  out  1  one-cycle completion pulse.
REQ-011 act_rd_en  out  1; act_rd_row  out  DIM_W (row-group base); act_rd_chunk  out  DIM_W; act_rd_data  in  MAC_NUM*ACCU_NUM*BW_ACT, valid 1 cycle after act_rd_en.
REQ-012 wet_rd_en  out  1; wet_rd_chunk  out  DIM_W; wet_rd_col  out  DIM_W; wet_rd_data  in  ACCU_NUM*BW_WET, valid 1 cycle after wet_rd_en.
REQ-013 pe_mac_enable, pe_clear_acc  out  1 each; pe_act_out  out  MAC_NUM*ACCU_NUM*BW_ACT; pe_wet_out  out  ACCU_NUM*BW_WET; pe_res_shift_num  out  8; pe_result_in  in  MAC_NUM*BW_ACT.
REQ-014 oa_wr_en  out  1; oa_wr_row, oa_wr_col  out  DIM_W; oa_wr_data  out  MAC_NUM*BW_ACT; oa_wr_mask  out  MAC_NUM (per-row write enable).

Function
REQ-015 FSM states SHALL be IDLE, FEED, DRAIN, CAPTURE, CLEAR, DONE.
REQ-016 IDLE->FEED on start; if any cfg dimension is zero, IDLE->DONE instead, with no reads or writes.
REQ-017 Loop order: column m outer (0..cfg_cols-1), row group j inner (step MAC_NUM), chunk c innermost (0..CHUNKS-1), CHUNKS = ceil(cfg_inner/ACCU_NUM).
REQ-018 FEED: one act and wet read per cycle for CHUNKS consecutive cycles, act_rd_row=j, act_rd_chunk=wet_rd_chunk=c, wet_rd_col=m.
REQ-019 Read data SHALL be registered to pe_act_out/pe_wet_out one cycle after the read; pe_clear_acc=0 during those cycles.
REQ-020 Padding: in the last chunk, lanes with index >= cfg_inner mod ACCU_NUM (when nonzero) SHALL be forced to zero in act and weight.
REQ-021 After the last read: DRAIN lasts ACCU_NUM_LOG2+3 cycles with pe_act_out/pe_wet_out driven to zero.
REQ-022 CAPTURE, 1 cycle: oa_wr_en=1, oa_wr_row=j, oa_wr_col=m, oa_wr_data=pe_result_in; oa_wr_mask bit n =1 iff j+n < cfg_rows.
REQ-023 CLEAR, 1 cycle: pe_clear_acc=1; then FEED for next (j,m), or DONE after the last group.
REQ-024 DONE: done=1 for one cycle, busy=0 in the following cycle, return to IDLE.
REQ-025 pe_mac_enable SHALL be 1 whenever busy.
REQ-026 Group period SHALL be exactly CHUNKS+ACCU_NUM_LOG2+5 cycles; no idle bubbles between groups.
REQ-027 start while busy SHALL be ignored; cfg changes while busy SHALL have no effect.

Reset
REQ-028 On reset: state IDLE, all counters 0, busy=done=0, all rd_en/wr_en=0, oa_wr_mask=0, pe_mac_enable=0, pe_clear_acc=1, pe data outputs 0, pe_res_shift_num=0.
REQ-029 Reset mid-job SHALL abort at once; no further reads or writes, and no done pulse.

Structure
REQ-030 Package mac_pkg SHALL hold the FSM state enum and the DRAIN_EXTRA=3 constant.
REQ-031 One sub-module, mac_loop_counter (nested chunk/row/column counters with last flags), is natural. The FSM, padding and output registers stay in the top module.

Verification
REQ-032 MAC_NUM=1, ACCU_NUM=2, rows=1, inner=4, cols=1, all ones. Required: 2 reads; one write at (0,0) of the model value; done at cycle 1+2+4+1+1.
REQ-033 inner=3, ACCU_NUM=2. Required: second chunk lane1 act and weight equal 0 on the PE ports, even when the memory holds 0x7F.
REQ-034 MAC_NUM=2, rows=3. Required: second group writes with oa_wr_mask=2'b01.
REQ-035 cols=0. Required: done one cycle after start; no rd_en/wr_en asserted.
REQ-036 Reset asserted in DRAIN of group 2. Required: all outputs take reset values next cycle; no oa write follows; a new start then runs cleanly.
REQ-037 Full 100x150x16 random job checked against the golden model; start pulsed while busy has no effect.

Source files
------------

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared FSM state type and timing constants for the MAC feed sequencer
package mac_pkg;

  // Sequencer phases; one feed/drain/capture/clear pass per output group
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FEED    = 3'd1,
    DRAIN   = 3'd2,
    CAPTURE = 3'd3,
    CLEAR   = 3'd4,
    DONE    = 3'd5
  } seq_state_t;

  // Drain cycles beyond the adder-tree depth: read latency, operand register, accumulate
  localparam int DRAIN_EXTRA = 3;

  // Number of ACCU-wide chunks needed to cover an inner length (ceiling division)
  function automatic logic [31:0] chunk_count(input logic [31:0] inner, input int log2);
    logic [32:0] w_sum;
    w_sum = {1'b0, inner} + 33'((1 << log2) - 1);
    return 32'(w_sum >> log2);
  endfunction

endpackage

// File: rtl/mac_loop_counter.sv
// rtl/mac_loop_counter.sv - nested chunk / row-group / column counters with last flags
module mac_loop_counter #(
  parameter int MAC_NUM = 1,
  parameter int DIM_W   = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic             i_step_chunk,
  input  logic             i_step_group,
  input  logic [DIM_W-1:0] i_chunks,
  input  logic [DIM_W-1:0] i_rows,
  input  logic [DIM_W-1:0] i_cols,
  output logic [DIM_W-1:0] o_chunk,
  output logic [DIM_W-1:0] o_row,
  output logic [DIM_W-1:0] o_col,
  output logic             o_last_chunk,
  output logic             o_last_row,
  output logic             o_last_col
);

  logic [DIM_W-1:0] r_chunk;
  logic [DIM_W-1:0] r_row;
  logic [DIM_W-1:0] r_col;
  logic [DIM_W:0]   w_row_next;

  // One extra bit so a row group near the top of the address range cannot wrap
  assign w_row_next   = {1'b0, r_row} + (DIM_W+1)'(MAC_NUM);

  assign o_last_chunk = (r_chunk == i_chunks - 1'b1);
  assign o_last_row   = (w_row_next >= {1'b0, i_rows});
  assign o_last_col   = (r_col == i_cols - 1'b1);

  assign o_chunk = r_chunk;
  assign o_row   = r_row;
  assign o_col   = r_col;

  // Chunk wraps every group; row group wraps into the next column
  always_ff @(posedge i_clk) begin
    if (i_reset || i_load) begin
      r_chunk <= '0;
      r_row   <= '0;
      r_col   <= '0;
    end else begin
      if (i_step_chunk) begin
        r_chunk <= o_last_chunk ? '0 : r_chunk + 1'b1;
      end
      if (i_step_group) begin
        if (o_last_row) begin
          r_row <= '0;
          r_col <= r_col + 1'b1;
        end else begin
          r_row <= w_row_next[DIM_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/mac_feed_sequencer.sv
// rtl/mac_feed_sequencer.sv - sequences activation/weight reads into the MAC array and writes results back
module mac_feed_sequencer #(
  parameter int MAC_NUM       = 1,
  parameter int ACCU_NUM_LOG2 = 1,
  parameter int BW_ACT        = 8,
  parameter int BW_WET        = 8,
  parameter int DIM_W         = 16
) (
  input  logic                                          i_clk,
  input  logic                                          i_reset,
  input  logic                                          i_start,
  input  logic [DIM_W-1:0]                              i_cfg_rows,
  input  logic [DIM_W-1:0]                              i_cfg_inner,
  input  logic [DIM_W-1:0]                              i_cfg_cols,
  input  logic [7:0]                                    i_cfg_shift,
  output logic                                          o_busy,
  output logic                                          o_done,
  output logic                                          o_act_rd_en,
  output logic [DIM_W-1:0]                              o_act_rd_row,
  output logic [DIM_W-1:0]                              o_act_rd_chunk,
  input  logic [MAC_NUM*(1<<ACCU_NUM_LOG2)*BW_ACT-1:0]  i_act_rd_data,
  output logic                                          o_wet_rd_en,
  output logic [DIM_W-1:0]                              o_wet_rd_chunk,
  output logic [DIM_W-1:0]                              o_wet_rd_col,
  input  logic [(1<<ACCU_NUM_LOG2)*BW_WET-1:0]          i_wet_rd_data,
  output logic                                          o_pe_mac_enable,
  output logic                                          o_pe_clear_acc,
  output logic [MAC_NUM*(1<<ACCU_NUM_LOG2)*BW_ACT-1:0]  o_pe_act_out,
  output logic [(1<<ACCU_NUM_LOG2)*BW_WET-1:0]          o_pe_wet_out,
  output logic [7:0]                                    o_pe_res_shift_num,
  input  logic [MAC_NUM*BW_ACT-1:0]                     i_pe_result_in,
  output logic                                          o_oa_wr_en,
  output logic [DIM_W-1:0]                              o_oa_wr_row,
  output logic [DIM_W-1:0]                              o_oa_wr_col,
  output logic [MAC_NUM*BW_ACT-1:0]                     o_oa_wr_data,
  output logic [MAC_NUM-1:0]                            o_oa_wr_mask
);

  import mac_pkg::*;

  localparam int ACCU_NUM  = 1 << ACCU_NUM_LOG2;
  localparam int ACT_W     = MAC_NUM * ACCU_NUM * BW_ACT;
  localparam int WET_W     = ACCU_NUM * BW_WET;
  localparam int DRAIN_LEN = ACCU_NUM_LOG2 + DRAIN_EXTRA;

  seq_state_t       r_state;
  seq_state_t       w_next_state;

  logic [DIM_W-1:0] r_rows;
  logic [DIM_W-1:0] r_cols;
  logic [DIM_W-1:0] r_chunks;
  logic [DIM_W-1:0] r_rem;
  logic [7:0]       r_shift;
  logic [7:0]       r_drain_cnt;

  logic             r_rd_d1;
  logic             r_last_d1;
  logic [ACT_W-1:0] r_act_out;
  logic [WET_W-1:0] r_wet_out;

  logic             w_load;
  logic             w_step_chunk;
  logic             w_step_group;
  logic             w_cfg_zero;
  logic [DIM_W-1:0] w_chunks;
  logic [DIM_W-1:0] w_rem;
  logic [DIM_W-1:0] w_chunk;
  logic [DIM_W-1:0] w_row;
  logic [DIM_W-1:0] w_col;
  logic             w_last_chunk;
  logic             w_last_row;
  logic             w_last_col;
  logic [ACCU_NUM-1:0] w_lane_keep;
  logic [ACT_W-1:0] w_act_pad;
  logic [WET_W-1:0] w_wet_pad;
  logic [MAC_NUM-1:0] w_mask;
  logic             w_feeding;
  logic             w_capture;

  assign w_cfg_zero = (i_cfg_rows == '0) || (i_cfg_inner == '0) || (i_cfg_cols == '0);
  assign w_chunks   = DIM_W'(chunk_count(32'(i_cfg_inner), ACCU_NUM_LOG2));
  assign w_rem      = i_cfg_inner & DIM_W'(ACCU_NUM - 1);
  assign w_feeding  = (r_state == FEED);
  assign w_capture  = (r_state == CAPTURE);

  mac_loop_counter #(
    .MAC_NUM (MAC_NUM),
    .DIM_W   (DIM_W)
  ) u_loop (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_load       (w_load),
    .i_step_chunk (w_step_chunk),
    .i_step_group (w_step_group),
    .i_chunks     (r_chunks),
    .i_rows       (r_rows),
    .i_cols       (r_cols),
    .o_chunk      (w_chunk),
    .o_row        (w_row),
    .o_col        (w_col),
    .o_last_chunk (w_last_chunk),
    .o_last_row   (w_last_row),
    .o_last_col   (w_last_col)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and counter control; a zero-sized job completes without touching memory
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_step_chunk = 1'b0;
    w_step_group = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_load       = 1'b1;
          w_next_state = w_cfg_zero ? DONE : FEED;
        end
      end
      FEED: begin
        w_step_chunk = 1'b1;
        if (w_last_chunk) begin
          w_next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (r_drain_cnt == 8'(DRAIN_LEN - 1)) begin
          w_next_state = CAPTURE;
        end
      end
      CAPTURE: begin
        w_next_state = CLEAR;
      end
      CLEAR: begin
        w_step_group = 1'b1;
        w_next_state = (w_last_row && w_last_col) ? DONE : FEED;
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Job configuration is captured only when a start is accepted, so later cfg edits are inert
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rows   <= '0;
      r_cols   <= '0;
      r_chunks <= '0;
      r_rem    <= '0;
      r_shift  <= '0;
    end else if (w_load) begin
      r_rows   <= i_cfg_rows;
      r_cols   <= i_cfg_cols;
      r_chunks <= w_chunks;
      r_rem    <= w_rem;
      r_shift  <= i_cfg_shift;
    end
  end

  // Counts drain cycles; idles at zero outside DRAIN
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_drain_cnt <= '0;
    end else if (r_state == DRAIN) begin
      r_drain_cnt <= r_drain_cnt + 1'b1;
    end else begin
      r_drain_cnt <= '0;
    end
  end

  // Lanes past the inner length in the final chunk must contribute nothing
  always_comb begin
    w_lane_keep = '1;
    for (int l = 0; l < ACCU_NUM; l++) begin
      if (r_last_d1 && (r_rem != '0) && (DIM_W'(l) >= r_rem)) begin
        w_lane_keep[l] = 1'b0;
      end
    end
  end

  // Zero the padded lanes of both operands as the read data arrives
  always_comb begin
    w_act_pad = '0;
    w_wet_pad = '0;
    for (int l = 0; l < ACCU_NUM; l++) begin
      if (w_lane_keep[l]) begin
        w_wet_pad[l*BW_WET +: BW_WET] = i_wet_rd_data[l*BW_WET +: BW_WET];
        for (int n = 0; n < MAC_NUM; n++) begin
          w_act_pad[(n*ACCU_NUM+l)*BW_ACT +: BW_ACT] = i_act_rd_data[(n*ACCU_NUM+l)*BW_ACT +: BW_ACT];
        end
      end
    end
  end

  // Operand pipeline: track which cycle carries valid read data, register it toward the PEs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rd_d1   <= 1'b0;
      r_last_d1 <= 1'b0;
      r_act_out <= '0;
      r_wet_out <= '0;
    end else begin
      r_rd_d1   <= w_feeding;
      r_last_d1 <= w_feeding && w_last_chunk;
      r_act_out <= r_rd_d1 ? w_act_pad : '0;
      r_wet_out <= r_rd_d1 ? w_wet_pad : '0;
    end
  end

  // Row n of the group is written only if it lies inside the output matrix
  always_comb begin
    w_mask = '0;
    for (int n = 0; n < MAC_NUM; n++) begin
      w_mask[n] = w_capture && (({1'b0, w_row} + (DIM_W+1)'(n)) < {1'b0, r_rows});
    end
  end

  assign o_busy             = (r_state != IDLE);
  assign o_done             = (r_state == DONE);
  assign o_pe_mac_enable    = o_busy;
  assign o_pe_clear_acc     = !(w_feeding || (r_state == DRAIN) || w_capture);
  assign o_pe_res_shift_num = r_shift;
  assign o_pe_act_out       = r_act_out;
  assign o_pe_wet_out       = r_wet_out;

  assign o_act_rd_en    = w_feeding;
  assign o_act_rd_row   = w_row;
  assign o_act_rd_chunk = w_chunk;
  assign o_wet_rd_en    = w_feeding;
  assign o_wet_rd_chunk = w_chunk;
  assign o_wet_rd_col   = w_col;

  assign o_oa_wr_en   = w_capture;
  assign o_oa_wr_row  = w_row;
  assign o_oa_wr_col  = w_col;
  assign o_oa_wr_data = w_capture ? i_pe_result_in : '0;
  assign o_oa_wr_mask = w_mask;

endmodule

// File: tb/tb_mac_feed_sequencer.sv
// tb/tb_mac_feed_sequencer.sv - scoreboard bench for mac_feed_sequencer with memory and PE models
module tb_mac_feed_sequencer;

  localparam int MAC_NUM = 2;
  localparam int LOG2    = 1;
  localparam int ACCU    = 2;
  localparam int BW      = 8;
  localparam int DIM_W   = 16;
  localparam int LIMIT   = 70000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      reset, start;
  logic [DIM_W-1:0]          cfg_rows, cfg_inner, cfg_cols;
  logic [7:0]                cfg_shift;
  logic                      busy, done;
  logic                      act_rd_en, wet_rd_en;
  logic [DIM_W-1:0]          act_rd_row, act_rd_chunk, wet_rd_chunk, wet_rd_col;
  logic [MAC_NUM*ACCU*BW-1:0] act_rd_data, pe_act_out;
  logic [ACCU*BW-1:0]        wet_rd_data, pe_wet_out;
  logic                      pe_mac_enable, pe_clear_acc;
  logic [7:0]                pe_res_shift_num;
  logic [MAC_NUM*BW-1:0]     pe_result_in, oa_wr_data;
  logic                      oa_wr_en;
  logic [DIM_W-1:0]          oa_wr_row, oa_wr_col;
  logic [MAC_NUM-1:0]        oa_wr_mask;

  mac_feed_sequencer #(
    .MAC_NUM(MAC_NUM), .ACCU_NUM_LOG2(LOG2), .BW_ACT(BW), .BW_WET(BW), .DIM_W(DIM_W)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start),
    .i_cfg_rows(cfg_rows), .i_cfg_inner(cfg_inner), .i_cfg_cols(cfg_cols), .i_cfg_shift(cfg_shift),
    .o_busy(busy), .o_done(done),
    .o_act_rd_en(act_rd_en), .o_act_rd_row(act_rd_row), .o_act_rd_chunk(act_rd_chunk),
    .i_act_rd_data(act_rd_data),
    .o_wet_rd_en(wet_rd_en), .o_wet_rd_chunk(wet_rd_chunk), .o_wet_rd_col(wet_rd_col),
    .i_wet_rd_data(wet_rd_data),
    .o_pe_mac_enable(pe_mac_enable), .o_pe_clear_acc(pe_clear_acc),
    .o_pe_act_out(pe_act_out), .o_pe_wet_out(pe_wet_out),
    .o_pe_res_shift_num(pe_res_shift_num), .i_pe_result_in(pe_result_in),
    .o_oa_wr_en(oa_wr_en), .o_oa_wr_row(oa_wr_row), .o_oa_wr_col(oa_wr_col),
    .o_oa_wr_data(oa_wr_data), .o_oa_wr_mask(oa_wr_mask)
  );

  logic [7:0] act_mem [0:127][0:255];
  logic [7:0] wet_mem [0:255][0:31];

  // Synchronous-read memories: data appears the cycle after the enable
  always @(posedge clk) begin
    if (act_rd_en) begin
      for (int n = 0; n < MAC_NUM; n++)
        for (int l = 0; l < ACCU; l++)
          act_rd_data[(n*ACCU+l)*BW +: BW] <= act_mem[(int'(act_rd_row)+n) % 128][(int'(act_rd_chunk)*ACCU+l) % 256];
    end
    if (wet_rd_en) begin
      for (int l = 0; l < ACCU; l++)
        wet_rd_data[l*BW +: BW] <= wet_mem[(int'(wet_rd_chunk)*ACCU+l) % 256][int'(wet_rd_col) % 32];
    end
  end

  int unsigned acc [MAC_NUM];

  function automatic int unsigned dot(input int n);
    int unsigned s;
    s = 0;
    for (int l = 0; l < ACCU; l++)
      s += 32'(pe_act_out[(n*ACCU+l)*BW +: BW]) * 32'(pe_wet_out[l*BW +: BW]);
    return s;
  endfunction

  // PE array model: accumulate every enabled cycle, clear on request
  always @(posedge clk) begin
    for (int n = 0; n < MAC_NUM; n++) begin
      if (pe_clear_acc) acc[n] <= 0;
      else if (pe_mac_enable) acc[n] <= acc[n] + dot(n);
    end
  end

  always_comb begin
    pe_result_in = '0;
    for (int n = 0; n < MAC_NUM; n++)
      pe_result_in[n*BW +: BW] = 8'(acc[n] >> pe_res_shift_num);
  end

  typedef struct {
    int                 row;
    int                 col;
    logic [MAC_NUM*BW-1:0] data;
    logic [MAC_NUM-1:0] mask;
  } wr_t;

  wr_t exp_q[$];
  int total = 0;
  int bad   = 0;
  logic [MAC_NUM*ACCU*BW-1:0] snap_act3, snap_act4;
  logic [ACCU*BW-1:0]         snap_wet4;
  logic [MAC_NUM*BW-1:0]      first_data;
  logic [MAC_NUM-1:0]         second_mask;
  int done_cyc, rd_cnt, wr_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, 64'(busy), 0);
    check({tag, "_done"}, 64'(done), 0);
    check({tag, "_rd_en"}, 64'({act_rd_en, wet_rd_en}), 0);
    check({tag, "_wr_en"}, 64'(oa_wr_en), 0);
    check({tag, "_mask"}, 64'(oa_wr_mask), 0);
    check({tag, "_mac_en"}, 64'(pe_mac_enable), 0);
    check({tag, "_clear"}, 64'(pe_clear_acc), 1);
    check({tag, "_pe_data"}, 64'({pe_act_out, pe_wet_out}), 0);
    check({tag, "_shift"}, 64'(pe_res_shift_num), 0);
    check({tag, "_addr"}, 64'({act_rd_row, act_rd_chunk, wet_rd_col}), 0);
  endtask

  task automatic fill_random();
    for (int r = 0; r < 128; r++) for (int k = 0; k < 256; k++) act_mem[r][k] = 8'($urandom);
    for (int k = 0; k < 256; k++) for (int c = 0; c < 32; c++) wet_mem[k][c] = 8'($urandom);
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int r = 0; r < 128; r++) for (int k = 0; k < 256; k++) act_mem[r][k] = v;
    for (int k = 0; k < 256; k++) for (int c = 0; c < 32; c++) wet_mem[k][c] = v;
  endtask

  // Golden model: one expected write per (column, row group) in column-outer order
  task automatic build_expected(input int rows, input int inner, input int cols, input int shift);
    wr_t e;
    int unsigned s;
    if (rows == 0 || inner == 0 || cols == 0) return;
    for (int m = 0; m < cols; m++) begin
      for (int j = 0; j < rows; j += MAC_NUM) begin
        e.row = j; e.col = m; e.data = '0; e.mask = '0;
        for (int n = 0; n < MAC_NUM; n++) begin
          if (j + n < rows) begin
            e.mask[n] = 1'b1;
            s = 0;
            for (int k = 0; k < inner; k++) s += 32'(act_mem[j+n][k]) * 32'(wet_mem[k][m]);
            e.data[n*BW +: BW] = 8'(s >> shift);
          end
        end
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic run_job(input int rows, input int inner, input int cols, input int shift,
                         input bit poke, input int abort_at);
    wr_t e;
    int cyc, last_wr, period, extra;
    bit zero, aborted;
    zero = (rows == 0 || inner == 0 || cols == 0);
    period = (inner + ACCU - 1) / ACCU + LOG2 + 5;
    build_expected(rows, inner, cols, shift);
    cfg_rows = 16'(rows); cfg_inner = 16'(inner); cfg_cols = 16'(cols); cfg_shift = 8'(shift);
    cyc = 0; last_wr = -1; done_cyc = -1; rd_cnt = 0; wr_cnt = 0; aborted = 0;
    start = 1'b1;
    while (cyc < LIMIT) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (cyc == 2) begin
        check("busy_running", 64'(busy), 64'(!zero));
        check("enable_tracks_busy", 64'(pe_mac_enable), 64'(!zero));
      end
      if (cyc == 3) snap_act3 = pe_act_out;
      if (cyc == 4) begin snap_act4 = pe_act_out; snap_wet4 = pe_wet_out; end
      if (act_rd_en) rd_cnt++;
      if (oa_wr_en) begin
        wr_cnt++;
        if (wr_cnt == 1) first_data = oa_wr_data;
        if (wr_cnt == 2) second_mask = oa_wr_mask;
        if (last_wr >= 0) check("group_period", 64'(cyc - last_wr), 64'(period));
        last_wr = cyc;
        if (exp_q.size() == 0) check("unexpected_write", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("wr_row", 64'(oa_wr_row), 64'(e.row));
          check("wr_col", 64'(oa_wr_col), 64'(e.col));
          check("wr_mask", 64'(oa_wr_mask), 64'(e.mask));
          for (int n = 0; n < MAC_NUM; n++)
            if (e.mask[n]) check("wr_data", 64'(oa_wr_data[n*BW +: BW]), 64'(e.data[n*BW +: BW]));
        end
      end
      if (done) begin done_cyc = cyc; break; end
      if (poke && cyc == 5) begin
        start = 1'b1;
        cfg_rows = cfg_rows ^ 16'h0055; cfg_cols = cfg_cols + 16'd3; cfg_shift = 8'd0;
      end
      if (abort_at > 0 && cyc == abort_at) begin aborted = 1; break; end
    end
    if (aborted) begin
      reset = 1'b1;
      @(negedge clk);
      check_reset_state("abort");
      reset = 1'b0;
      exp_q.delete();
      extra = 0;
      repeat (20) begin
        @(negedge clk);
        if (act_rd_en || wet_rd_en || oa_wr_en || done) extra++;
      end
      check("abort_quiet", 64'(extra), 0);
    end else begin
      if (done_cyc < 0) check("done_timeout", 0, 1);
      check("sb_empty", 64'(exp_q.size()), 0);
      exp_q.delete();
      @(negedge clk);
      check("busy_after_done", 64'(busy), 0);
      check("done_one_cycle", 64'(done), 0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    cfg_rows = '0; cfg_inner = '0; cfg_cols = '0; cfg_shift = '0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;
    @(negedge clk);

    // Minimal job, all ones: 2 chunks of 2 lanes sum to 4
    fill_const(8'd1);
    run_job(1, 4, 1, 0, 0, 0);
    check("t1_done_cycle", 64'(done_cyc), 9);
    check("t1_reads", 64'(rd_cnt), 2);
    check("t1_writes", 64'(wr_cnt), 1);
    check("t1_data", 64'(first_data[7:0]), 4);

    // Padding: inner=3 leaves lane1 of the second chunk out of range
    fill_const(8'h7F);
    act_mem[0][0] = 8'd1; act_mem[0][1] = 8'd2; act_mem[0][2] = 8'd3;
    wet_mem[0][0] = 8'd1; wet_mem[1][0] = 8'd1; wet_mem[2][0] = 8'd1;
    run_job(1, 3, 1, 0, 0, 0);
    check("pad_chunk0_lane1", 64'(snap_act3[15:8]), 2);
    check("pad_chunk1_lane0", 64'(snap_act4[7:0]), 3);
    check("pad_act_lane1", 64'(snap_act4[15:8]), 0);
    check("pad_act_row1_lane1", 64'(snap_act4[31:24]), 0);
    check("pad_wet_lane1", 64'(snap_wet4[15:8]), 0);
    check("pad_result", 64'(first_data[7:0]), 6);
    check("pad_done_cycle", 64'(done_cyc), 9);

    // Partial last row group: rows=3 with two MAC rows
    fill_random();
    run_job(3, 5, 2, 1, 0, 0);
    check("t3_second_mask", 64'(second_mask), 64'(2'b01));
    check("t3_reads", 64'(rd_cnt), 12);
    check("t3_writes", 64'(wr_cnt), 4);
    check("t3_done_cycle", 64'(done_cyc), 37);

    // Zero-sized jobs finish immediately without memory traffic
    run_job(3, 3, 0, 0, 0, 0);
    check("zcol_done_cycle", 64'(done_cyc), 1);
    check("zcol_traffic", 64'(rd_cnt + wr_cnt), 0);
    run_job(2, 0, 1, 0, 0, 0);
    check("zinner_done_cycle", 64'(done_cyc), 1);
    check("zinner_traffic", 64'(rd_cnt + wr_cnt), 0);

    // Reset during the DRAIN of the second group, then a clean job
    run_job(4, 4, 1, 2, 0, 12);
    check("abort_writes_before", 64'(wr_cnt), 1);
    run_job(2, 2, 1, 0, 0, 0);
    check("post_abort_done_cycle", 64'(done_cyc), 8);
    check("post_abort_writes", 64'(wr_cnt), 1);

    // Full random job with a start poke and cfg edits while busy
    fill_random();
    run_job(100, 150, 16, 4, 1, 0);
    check("full_writes", 64'(wr_cnt), 800);
    check("full_reads", 64'(rd_cnt), 60000);
    check("full_done_cycle", 64'(done_cyc), 64801);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
